// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control sequencer:
// opcodes, ALU codes, state encodings, select codes and the control bundle.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_RWB      = 4'd3,
    S_EXEC_I   = 4'd4,
    S_IWB      = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_FAULT    = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    FLT_NONE = 2'b00,
    FLT_ILL  = 2'b01,
    FLT_TMO  = 2'b10
  } fault_t;

  typedef struct packed {
    logic       pc_wen;
    logic [1:0] pc_src;
    logic       ir_wen;
    logic       mem_ren;
    logic       mem_wen;
    logic       addr_sel;
    logic       rf_wen;
    logic       rf_dst;
    logic       data_sel;
    logic       src_a;
    logic [1:0] src_b;
    logic [3:0] alu_ct;
    logic       retired;
  } ctl_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Memory request/ready handshake between the sequencer and the
// shared instruction/data memory.
interface mc_ctrl_fsm_if;
  logic mem_ren;
  logic mem_wen;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_ren,
    output mem_wen,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_ren,
    input  mem_wen,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Saturating wait counter; expired flags the count sitting at LIMIT.
// LIMIT of 0 never expires.
module mc_wait_timer #(
  parameter int unsigned LIMIT = 15,
  parameter int unsigned W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != '1) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (LIMIT != 0) && (cnt == W'(LIMIT));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer: addu, addiu, lw, sw, beq, j over a
// shared memory/ALU/register file, with memory stall and timeout.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TMO_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  mc_ctrl_fsm_if.master mem,
  output logic       pc_wen,
  output logic [1:0] pc_src,
  output logic       ir_wen,
  output logic       rf_wen,
  output logic       rf_dst,
  output logic       rf_data_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_ct,
  output logic       inst_retired,
  output logic [1:0] fault,
  output logic [3:0] state
);

  state_t state_q, state_d;
  fault_t fault_q, fault_d;
  logic   wait_st, tmo_hit, tmo;
  ctl_t   c;

  assign wait_st = (state_q == S_FETCH) ||
                   (state_q == S_MEM_RD) ||
                   (state_q == S_MEM_WR);

  mc_wait_timer #(
    .LIMIT (MEM_TIMEOUT),
    .W     (TMO_W)
  ) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_d != state_q),
    .inc     (wait_st && !mem.mem_ready),
    .expired (tmo_hit)
  );

  assign tmo = tmo_hit && wait_st && !mem.mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      fault_q <= FLT_NONE;
    end else begin
      state_q <= state_d;
      if (state_d == S_FAULT && state_q != S_FAULT)
        fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fault_d = FLT_NONE;
    case (state_q)
      S_FETCH: begin
        if (mem.mem_ready) begin
          state_d = S_DECODE;
        end else if (tmo) begin
          state_d = S_FAULT;
          fault_d = FLT_TMO;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_ADDU) begin
              state_d = S_EXEC_R;
            end else begin
              state_d = S_FAULT;
              fault_d = FLT_ILL;
            end
          end
          OP_ADDIU: state_d = S_EXEC_I;
          OP_LW,
          OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ:   state_d = S_BRANCH;
          OP_J:     state_d = S_JUMP;
          default: begin
            state_d = S_FAULT;
            fault_d = FLT_ILL;
          end
        endcase
      end
      S_EXEC_R: state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_EXEC_I: state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_MEM_ADDR: begin
        state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        if (mem.mem_ready) begin
          state_d = S_MEM_WB;
        end else if (tmo) begin
          state_d = S_FAULT;
          fault_d = FLT_TMO;
        end
      end
      S_MEM_WB: state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem.mem_ready) begin
          state_d = S_FETCH;
        end else if (tmo) begin
          state_d = S_FAULT;
          fault_d = FLT_TMO;
        end
      end
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      // unused encodings are treated as a corrupted instruction
      default: begin
        state_d = S_FAULT;
        fault_d = FLT_ILL;
      end
    endcase
  end

  always_comb begin
    c        = '0;
    c.alu_ct = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        c.mem_ren = 1'b1;
        c.src_b   = SRCB_4;
        c.pc_src  = PC_SEQ;
        c.ir_wen  = mem.mem_ready;
        c.pc_wen  = mem.mem_ready;
      end
      S_DECODE: c.src_b = SRCB_BOFF;
      S_EXEC_R: c.src_a = 1'b1;
      S_RWB: begin
        c.rf_wen  = 1'b1;
        c.rf_dst  = 1'b1;
        c.retired = 1'b1;
      end
      S_EXEC_I,
      S_MEM_ADDR: begin
        c.src_a = 1'b1;
        c.src_b = SRCB_IMM;
      end
      S_IWB: begin
        c.rf_wen  = 1'b1;
        c.retired = 1'b1;
      end
      S_MEM_RD: begin
        c.mem_ren  = 1'b1;
        c.addr_sel = 1'b1;
      end
      S_MEM_WB: begin
        c.rf_wen   = 1'b1;
        c.data_sel = 1'b1;
        c.retired  = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_wen  = 1'b1;
        c.addr_sel = 1'b1;
        c.retired  = mem.mem_ready;
      end
      S_BRANCH: begin
        c.src_a   = 1'b1;
        c.src_b   = SRCB_RT;
        c.alu_ct  = ALU_SUB;
        c.pc_src  = PC_BR;
        c.pc_wen  = alu_zero;
        c.retired = 1'b1;
      end
      S_JUMP: begin
        c.pc_wen  = 1'b1;
        c.pc_src  = PC_JMP;
        c.retired = 1'b1;
      end
      default: ;
    endcase
    // reset silences every output, even the FETCH defaults
    if (!rst) c = '0;
  end

  assign pc_wen           = c.pc_wen;
  assign pc_src           = c.pc_src;
  assign ir_wen           = c.ir_wen;
  assign mem.mem_ren      = c.mem_ren;
  assign mem.mem_wen      = c.mem_wen;
  assign mem.mem_addr_sel = c.addr_sel;
  assign rf_wen           = c.rf_wen;
  assign rf_dst           = c.rf_dst;
  assign rf_data_sel      = c.data_sel;
  assign alu_src_a        = c.src_a;
  assign alu_src_b        = c.src_b;
  assign alu_ct           = c.alu_ct;
  assign inst_retired     = c.retired;
  assign fault            = rst ? fault_q : FLT_NONE;
  assign state            = rst ? state_q : 4'd0;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed vector bench for mc_ctrl_fsm: per-cycle state and control
// word against hand-computed values, plus reset/timeout sequences.
module tb_mc_ctrl_fsm;

  localparam logic [3:0] F  = 4'd0,  D  = 4'd1,  XR = 4'd2,  RW = 4'd3;
  localparam logic [3:0] XI = 4'd4,  IW = 4'd5,  MA = 4'd6,  MR = 4'd7;
  localparam logic [3:0] MB = 4'd8,  MW = 4'd9,  BR = 4'd10, JP = 4'd11;
  localparam logic [3:0] FT = 4'd12;
  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110;

  localparam logic [5:0] ADDIU = 6'b001001, LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010, RT = 6'b000000;
  localparam logic [5:0] ADDU = 6'b100001;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [19:0] ctl;
  } vec_t;

  logic       clk, rst;
  logic [5:0] opcode, funct;
  logic       alu_zero;
  logic       pc_wen, ir_wen, rf_wen, rf_dst, rf_data_sel;
  logic       alu_src_a, inst_retired;
  logic [1:0] pc_src, alu_src_b, fault;
  logic [3:0] alu_ct, state;
  logic [23:0] act;

  int n_vec = 0;
  int n_err = 0;
  vec_t tv[$];

  logic [19:0] C_FR, C_FW, C_DE, C_XR, C_RW, C_XI, C_IW, C_MR, C_MB;
  logic [19:0] C_MW0, C_MW1, C_BT, C_BN, C_JP, C_FI, C_FT;

  mc_ctrl_fsm_if mif ();

  mc_ctrl_fsm #(.MEM_TIMEOUT(15), .TMO_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct        (funct),
    .alu_zero     (alu_zero),
    .mem          (mif),
    .pc_wen       (pc_wen),
    .pc_src       (pc_src),
    .ir_wen       (ir_wen),
    .rf_wen       (rf_wen),
    .rf_dst       (rf_dst),
    .rf_data_sel  (rf_data_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_ct       (alu_ct),
    .inst_retired (inst_retired),
    .fault        (fault),
    .state        (state)
  );

  assign act = {state, pc_wen, pc_src, ir_wen, mif.mem_ren, mif.mem_wen,
                mif.mem_addr_sel, rf_wen, rf_dst, rf_data_sel,
                alu_src_a, alu_src_b, alu_ct, inst_retired, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] mk(
    input logic pcw, input logic [1:0] pcs, input logic irw,
    input logic mr, input logic mw, input logic as, input logic rfw,
    input logic rd, input logic ds, input logic sa,
    input logic [1:0] sb, input logic [3:0] ct, input logic ret,
    input logic [1:0] flt);
    return {pcw, pcs, irw, mr, mw, as, rfw, rd, ds, sa, sb, ct, ret, flt};
  endfunction

  task automatic add(input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rdy,
                     input logic [3:0] st, input logic [19:0] ctl);
    tv.push_back('{op, fn, z, rdy, st, ctl});
  endtask

  task automatic check(input string nm, input logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy);
    opcode        = op;
    funct         = fn;
    alu_zero      = z;
    mif.mem_ready = rdy;
  endtask

  task automatic step(input string nm, input logic [5:0] op,
                      input logic [5:0] fn, input logic z,
                      input logic rdy, input logic [3:0] st,
                      input logic [19:0] ctl);
    drive(op, fn, z, rdy);
    #1;
    check(nm, {st, ctl});
    @(negedge clk);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check(nm, 24'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    C_FR  = mk(1, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, ADD, 0, 2'b00);
    C_FW  = mk(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, ADD, 0, 2'b00);
    C_DE  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, ADD, 0, 2'b00);
    C_XR  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, ADD, 0, 2'b00);
    C_RW  = mk(0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, ADD, 1, 2'b00);
    C_XI  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, ADD, 0, 2'b00);
    C_IW  = mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, ADD, 1, 2'b00);
    C_MR  = mk(0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, ADD, 0, 2'b00);
    C_MB  = mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, ADD, 1, 2'b00);
    C_MW0 = mk(0, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, ADD, 0, 2'b00);
    C_MW1 = mk(0, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, ADD, 1, 2'b00);
    C_BT  = mk(1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, SUB, 1, 2'b00);
    C_BN  = mk(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, SUB, 1, 2'b00);
    C_JP  = mk(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, ADD, 1, 2'b00);
    C_FI  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, ADD, 0, 2'b01);
    C_FT  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, ADD, 0, 2'b10);

    // addiu: 4 cycles
    add(ADDIU, 0, 0, 1, F,  C_FR);
    add(ADDIU, 0, 0, 1, D,  C_DE);
    add(ADDIU, 0, 0, 1, XI, C_XI);
    add(ADDIU, 0, 0, 1, IW, C_IW);
    // addu: 4 cycles
    add(RT, ADDU, 0, 1, F,  C_FR);
    add(RT, ADDU, 0, 1, D,  C_DE);
    add(RT, ADDU, 0, 1, XR, C_XR);
    add(RT, ADDU, 0, 1, RW, C_RW);
    // lw with three stall cycles: 8 cycles
    add(LW, 0, 0, 1, F,  C_FR);
    add(LW, 0, 0, 1, D,  C_DE);
    add(LW, 0, 0, 1, MA, C_XI);
    add(LW, 0, 0, 0, MR, C_MR);
    add(LW, 0, 0, 0, MR, C_MR);
    add(LW, 0, 0, 0, MR, C_MR);
    add(LW, 0, 0, 1, MR, C_MR);
    add(LW, 0, 0, 1, MB, C_MB);
    // sw with one stall cycle
    add(SW, 0, 0, 1, F,  C_FR);
    add(SW, 0, 0, 1, D,  C_DE);
    add(SW, 0, 0, 1, MA, C_XI);
    add(SW, 0, 0, 0, MW, C_MW0);
    add(SW, 0, 0, 1, MW, C_MW1);
    // beq taken, then not taken
    add(BEQ, 0, 1, 1, F,  C_FR);
    add(BEQ, 0, 1, 1, D,  C_DE);
    add(BEQ, 0, 1, 1, BR, C_BT);
    add(BEQ, 0, 0, 1, F,  C_FR);
    add(BEQ, 0, 0, 1, D,  C_DE);
    add(BEQ, 0, 0, 1, BR, C_BN);
    // j with two fetch stalls
    add(JMP, 0, 0, 0, F,  C_FW);
    add(JMP, 0, 0, 0, F,  C_FW);
    add(JMP, 0, 0, 1, F,  C_FR);
    add(JMP, 0, 0, 1, D,  C_DE);
    add(JMP, 0, 0, 1, JP, C_JP);
    // illegal opcode: sticky fault, enables quiet
    add(6'b111111, 0, 0, 1, F,  C_FR);
    add(6'b111111, 0, 0, 1, D,  C_DE);
    add(6'b111111, 0, 1, 1, FT, C_FI);
    add(ADDIU,     0, 1, 1, FT, C_FI);

    rst = 1'b0;
    drive(0, 0, 0, 0);
    #7;
    check("reset_outputs_idle", 24'h0);
    mif.mem_ready = 1'b1;
    #1;
    check("reset_outputs_ready", 24'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tv.size(); i++)
      step($sformatf("vec%0d", i), tv[i].op, tv[i].fn, tv[i].z,
           tv[i].rdy, tv[i].st, tv[i].ctl);

    // R-type with unsupported funct
    do_reset("reset_after_ill");
    step("rt_bad_fetch", RT, 6'b100000, 0, 1, F,  C_FR);
    step("rt_bad_dec",   RT, 6'b100000, 0, 1, D,  C_DE);
    step("rt_bad_flt",   RT, 6'b100000, 0, 1, FT, C_FI);
    step("rt_bad_hold",  RT, 6'b100000, 0, 1, FT, C_FI);

    // fetch timeout: 16th stalled cycle faults
    do_reset("reset_after_rt");
    for (int i = 0; i < 16; i++)
      step($sformatf("tmo_wait%0d", i), JMP, 0, 0, 0, F, C_FW);
    step("tmo_fault", JMP, 0, 0, 1, FT, C_FT);
    step("tmo_hold",  JMP, 0, 0, 1, FT, C_FT);

    // ready arriving as the count hits the limit wins
    do_reset("reset_after_tmo");
    for (int i = 0; i < 15; i++)
      step($sformatf("edge_wait%0d", i), JMP, 0, 0, 0, F, C_FW);
    step("edge_ready", JMP, 0, 0, 1, F,  C_FR);
    step("edge_dec",   JMP, 0, 0, 1, D,  C_DE);
    step("edge_jump",  JMP, 0, 0, 1, JP, C_JP);

    // async reset in the middle of a stalled store
    do_reset("reset_before_sw");
    step("sw_fetch", SW, 0, 0, 1, F,  C_FR);
    step("sw_dec",   SW, 0, 0, 1, D,  C_DE);
    step("sw_addr",  SW, 0, 0, 1, MA, C_XI);
    drive(SW, 0, 0, 0);
    #1;
    check("sw_wait", {MW, C_MW0});
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_now", 24'h0);
    @(negedge clk);
    check("async_rst_held", 24'h0);
    rst = 1'b1;
    step("post_rst_fetch", JMP, 0, 0, 1, F,  C_FR);
    step("post_rst_dec",   JMP, 0, 0, 1, D,  C_DE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
